// File: rtl/if_mem_arbiter_pkg.sv
// Shared types and bus widths for the IF/MEM memory-port arbiter.
package if_mem_arbiter_pkg;

  localparam int DATA_BUS      = 64;
  localparam int DATA_ADDR_BUS = 64;
  localparam int DATA_BUS_SIZE = 2;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'b00,
    ARB_GNT_IF  = 2'b01,
    ARB_GNT_MEM = 2'b10
  } arb_state_e;

endpackage

// File: rtl/if_mem_arb_fwd_mux.sv
// Combinational request/response steering between the two requesters and the
// shared bus, keyed by the current grant.
module if_mem_arb_fwd_mux
  import if_mem_arbiter_pkg::*;
(
  input  logic                     gnt_if,
  input  logic                     gnt_mem,
  input  logic [DATA_ADDR_BUS-1:0] if_addr,
  input  logic [DATA_BUS_SIZE-1:0] if_size,
  output logic                     if_ready,
  output logic [DATA_BUS-1:0]      if_data_read,
  output logic [1:0]               if_resp,
  input  logic [DATA_BUS-1:0]      mem_data_write,
  input  logic [DATA_ADDR_BUS-1:0] mem_addr,
  input  logic [DATA_BUS_SIZE-1:0] mem_size,
  input  logic                     mem_req,
  output logic                     mem_ready,
  output logic [DATA_BUS-1:0]      mem_data_read,
  output logic [1:0]               mem_resp,
  output logic                     bus_valid,
  input  logic                     bus_ready,
  input  logic [DATA_BUS-1:0]      bus_data_read,
  output logic [DATA_BUS-1:0]      bus_data_write,
  output logic [DATA_ADDR_BUS-1:0] bus_addr,
  output logic [DATA_BUS_SIZE-1:0] bus_size,
  input  logic [1:0]               bus_resp,
  output logic                     bus_req
);

  always_comb begin
    if_ready       = 1'b0;
    if_data_read   = '0;
    if_resp        = '0;
    mem_ready      = 1'b0;
    mem_data_read  = '0;
    mem_resp       = '0;
    bus_valid      = 1'b0;
    bus_data_write = '0;
    bus_addr       = '0;
    bus_size       = '0;
    bus_req        = 1'b0;
    if (gnt_if) begin
      bus_valid = 1'b1;
      bus_addr  = if_addr;
      bus_size  = if_size;
      // Read data and response only leave the arbiter on the completion pulse.
      if (bus_ready) begin
        if_ready     = 1'b1;
        if_data_read = bus_data_read;
        if_resp      = bus_resp;
      end
    end else if (gnt_mem) begin
      bus_valid      = 1'b1;
      bus_addr       = mem_addr;
      bus_size       = mem_size;
      bus_data_write = mem_data_write;
      bus_req        = mem_req;
      if (bus_ready) begin
        mem_ready     = 1'b1;
        mem_data_read = bus_data_read;
        mem_resp      = bus_resp;
      end
    end
  end

endmodule

// File: rtl/if_mem_arbiter.sv
// Arbiter sharing the core memory port between IF (read-only) and MEM (r/w).
// Optional completion counters are enabled with IF_MEM_ARB_PERF_EN.
module if_mem_arbiter
  import if_mem_arbiter_pkg::*;
#(
  parameter int MEM_BURST_MAX = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     if_mem_arb_if_valid_i,
  output logic                     if_mem_arb_if_ready_o,
  output logic [DATA_BUS-1:0]      if_mem_arb_if_data_read_o,
  input  logic [DATA_ADDR_BUS-1:0] if_mem_arb_if_addr_i,
  input  logic [DATA_BUS_SIZE-1:0] if_mem_arb_if_size_i,
  output logic [1:0]               if_mem_arb_if_resp_o,
  input  logic                     if_mem_arb_mem_valid_i,
  output logic                     if_mem_arb_mem_ready_o,
  output logic [DATA_BUS-1:0]      if_mem_arb_mem_data_read_o,
  input  logic [DATA_BUS-1:0]      if_mem_arb_mem_data_write_i,
  input  logic [DATA_ADDR_BUS-1:0] if_mem_arb_mem_addr_i,
  input  logic [DATA_BUS_SIZE-1:0] if_mem_arb_mem_size_i,
  output logic [1:0]               if_mem_arb_mem_resp_o,
  input  logic                     if_mem_arb_mem_req_i,
  output logic                     if_mem_arb_bus_valid_o,
  input  logic                     if_mem_arb_bus_ready_i,
  input  logic [DATA_BUS-1:0]      if_mem_arb_bus_data_read_i,
  output logic [DATA_BUS-1:0]      if_mem_arb_bus_data_write_o,
  output logic [DATA_ADDR_BUS-1:0] if_mem_arb_bus_addr_o,
  output logic [DATA_BUS_SIZE-1:0] if_mem_arb_bus_size_o,
  input  logic [1:0]               if_mem_arb_bus_resp_i,
`ifdef IF_MEM_ARB_PERF_EN
  output logic [63:0]              if_mem_arb_if_gnt_cnt_o,
  output logic [63:0]              if_mem_arb_mem_gnt_cnt_o,
`endif
  output logic                     if_mem_arb_bus_req_o
);

  localparam logic [3:0] BURST_MAX = 4'(MEM_BURST_MAX);

  arb_state_e state_reg, state_next;
  logic [3:0] cnt_reg, cnt_next;
  logic       if_starved;

  assign if_starved = if_mem_arb_if_valid_i && (cnt_reg == BURST_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ARB_IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ARB_IDLE: begin
        if (if_mem_arb_mem_valid_i && !if_starved) begin
          state_next = ARB_GNT_MEM;
          // Count only MEM grants that IF actually had to wait through.
          if (!if_mem_arb_if_valid_i)  cnt_next = '0;
          else if (cnt_reg != BURST_MAX) cnt_next = cnt_reg + 4'd1;
        end else if (if_mem_arb_if_valid_i) begin
          state_next = ARB_GNT_IF;
          cnt_next   = '0;
        end
      end
      ARB_GNT_IF, ARB_GNT_MEM: begin
        if (if_mem_arb_bus_ready_i) state_next = ARB_IDLE;
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  if_mem_arb_fwd_mux u_fwd_mux (
    .gnt_if         (state_reg == ARB_GNT_IF),
    .gnt_mem        (state_reg == ARB_GNT_MEM),
    .if_addr        (if_mem_arb_if_addr_i),
    .if_size        (if_mem_arb_if_size_i),
    .if_ready       (if_mem_arb_if_ready_o),
    .if_data_read   (if_mem_arb_if_data_read_o),
    .if_resp        (if_mem_arb_if_resp_o),
    .mem_data_write (if_mem_arb_mem_data_write_i),
    .mem_addr       (if_mem_arb_mem_addr_i),
    .mem_size       (if_mem_arb_mem_size_i),
    .mem_req        (if_mem_arb_mem_req_i),
    .mem_ready      (if_mem_arb_mem_ready_o),
    .mem_data_read  (if_mem_arb_mem_data_read_o),
    .mem_resp       (if_mem_arb_mem_resp_o),
    .bus_valid      (if_mem_arb_bus_valid_o),
    .bus_ready      (if_mem_arb_bus_ready_i),
    .bus_data_read  (if_mem_arb_bus_data_read_i),
    .bus_data_write (if_mem_arb_bus_data_write_o),
    .bus_addr       (if_mem_arb_bus_addr_o),
    .bus_size       (if_mem_arb_bus_size_o),
    .bus_resp       (if_mem_arb_bus_resp_i),
    .bus_req        (if_mem_arb_bus_req_o)
  );

`ifdef IF_MEM_ARB_PERF_EN
  logic [63:0] if_gnt_cnt_reg, mem_gnt_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      if_gnt_cnt_reg  <= '0;
      mem_gnt_cnt_reg <= '0;
    end else begin
      if (if_mem_arb_if_ready_o)  if_gnt_cnt_reg  <= if_gnt_cnt_reg + 64'd1;
      if (if_mem_arb_mem_ready_o) mem_gnt_cnt_reg <= mem_gnt_cnt_reg + 64'd1;
    end
  end

  assign if_mem_arb_if_gnt_cnt_o  = if_gnt_cnt_reg;
  assign if_mem_arb_mem_gnt_cnt_o = mem_gnt_cnt_reg;
`endif

endmodule

// File: tb/tb_if_mem_arbiter.sv
// Directed bench for if_mem_arbiter with a per-cycle reference model.
module tb_if_mem_arbiter;

  localparam int MAX = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_v, mem_v, mem_req, bus_ready;
  logic [63:0] if_addr, mem_addr, mem_wdata, bus_rdata;
  logic [1:0]  if_size, mem_size, bus_resp;
  logic        if_ready, mem_ready, bus_valid, bus_req;
  logic [63:0] if_rdata, mem_rdata, bus_wdata, bus_addr;
  logic [1:0]  if_resp, mem_resp, bus_size;
`ifdef IF_MEM_ARB_PERF_EN
  logic [63:0] if_cnt, mem_cnt;
`endif

  int vectors = 0;
  int errors  = 0;
  bit chk_en  = 0;
  int order[$];

  // Model: who owns the bus, how many MEM grants IF has sat through, completions.
  int          m_own  = 0;
  int          m_wait = 0;
  logic [63:0] m_ifc  = '0;
  logic [63:0] m_memc = '0;

  always #5 clk = ~clk;

  if_mem_arbiter #(.MEM_BURST_MAX(MAX)) dut (
    .clk                         (clk),
    .rst                         (rst),
    .if_mem_arb_if_valid_i       (if_v),
    .if_mem_arb_if_ready_o       (if_ready),
    .if_mem_arb_if_data_read_o   (if_rdata),
    .if_mem_arb_if_addr_i        (if_addr),
    .if_mem_arb_if_size_i        (if_size),
    .if_mem_arb_if_resp_o        (if_resp),
    .if_mem_arb_mem_valid_i      (mem_v),
    .if_mem_arb_mem_ready_o      (mem_ready),
    .if_mem_arb_mem_data_read_o  (mem_rdata),
    .if_mem_arb_mem_data_write_i (mem_wdata),
    .if_mem_arb_mem_addr_i       (mem_addr),
    .if_mem_arb_mem_size_i       (mem_size),
    .if_mem_arb_mem_resp_o       (mem_resp),
    .if_mem_arb_mem_req_i        (mem_req),
    .if_mem_arb_bus_valid_o      (bus_valid),
    .if_mem_arb_bus_ready_i      (bus_ready),
    .if_mem_arb_bus_data_read_i  (bus_rdata),
    .if_mem_arb_bus_data_write_o (bus_wdata),
    .if_mem_arb_bus_addr_o       (bus_addr),
    .if_mem_arb_bus_size_o       (bus_size),
    .if_mem_arb_bus_resp_i       (bus_resp),
`ifdef IF_MEM_ARB_PERF_EN
    .if_mem_arb_if_gnt_cnt_o     (if_cnt),
    .if_mem_arb_mem_gnt_cnt_o    (mem_cnt),
`endif
    .if_mem_arb_bus_req_o        (bus_req)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_own <= 0; m_wait <= 0; m_ifc <= '0; m_memc <= '0;
    end else if (m_own == 0) begin
      if (mem_v && !(if_v && m_wait >= MAX)) begin
        m_own  <= 2;
        m_wait <= if_v ? ((m_wait < MAX) ? m_wait + 1 : MAX) : 0;
      end else if (if_v) begin
        m_own  <= 1;
        m_wait <= 0;
      end
    end else if (bus_ready) begin
      if (m_own == 1) m_ifc <= m_ifc + 64'd1;
      else            m_memc <= m_memc + 64'd1;
      m_own <= 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("bus_valid", 64'(bus_valid), 64'(m_own != 0));
      check("bus_addr",  bus_addr,  m_own == 1 ? if_addr : m_own == 2 ? mem_addr : 64'd0);
      check("bus_size",  64'(bus_size), 64'(m_own == 1 ? if_size : m_own == 2 ? mem_size : 2'd0));
      check("bus_req",   64'(bus_req), 64'(m_own == 2 && mem_req));
      check("bus_wdata", bus_wdata, m_own == 2 ? mem_wdata : 64'd0);
      check("if_ready",  64'(if_ready),  64'(m_own == 1 && bus_ready));
      check("mem_ready", 64'(mem_ready), 64'(m_own == 2 && bus_ready));
      if (!(m_own == 1 && !bus_ready)) begin
        check("if_rdata", if_rdata, (m_own == 1) ? bus_rdata : 64'd0);
        check("if_resp",  64'(if_resp), 64'((m_own == 1) ? bus_resp : 2'd0));
      end
      if (!(m_own == 2 && !bus_ready)) begin
        check("mem_rdata", mem_rdata, (m_own == 2) ? bus_rdata : 64'd0);
        check("mem_resp",  64'(mem_resp), 64'((m_own == 2) ? bus_resp : 2'd0));
      end
`ifdef IF_MEM_ARB_PERF_EN
      check("if_gnt_cnt",  if_cnt,  m_ifc);
      check("mem_gnt_cnt", mem_cnt, m_memc);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Slave answers in the same cycle a request appears; logs which side completed.
  task automatic run_auto(input int n);
    for (int k = 0; k < n; k++) begin
      tick();
      bus_ready = bus_valid;
      bus_rdata = {$urandom, $urandom};
      bus_resp  = 2'($urandom);
      #1;
      if (if_ready)       order.push_back(1);
      else if (mem_ready) order.push_back(2);
    end
    bus_ready = 1'b0;
  endtask

  task automatic check_order(input string nm, input int exp[], input int n);
    check({nm, "_len"}, 64'(order.size() >= n), 64'd1);
    for (int i = 0; i < n && i < order.size(); i++)
      check($sformatf("%s_%0d", nm, i), 64'(order[i]), 64'(exp[i]));
  endtask

  initial begin
    int exp_a[];
    int exp_b[];
    exp_a = '{2, 2, 2, 2, 1, 2, 2};
    exp_b = '{2, 2, 2, 2, 1};
    rst = 1; if_v = 0; mem_v = 0; mem_req = 0; bus_ready = 0;
    if_addr = '0; mem_addr = '0; mem_wdata = '0; bus_rdata = '0;
    if_size = '0; mem_size = '0; bus_resp = '0;
    tick();
    chk_en = 1;
    tick();
    check("rst_bus_valid", 64'(bus_valid), 64'd0);
    check("rst_if_ready",  64'(if_ready), 64'd0);
    rst = 0;

    // Lone IF read
    if_v = 1; if_addr = 64'h8000_0000; if_size = 2'b10;
    tick(); #1;
    check("if_c1_valid", 64'(bus_valid), 64'd1);
    check("if_c1_addr",  bus_addr, 64'h8000_0000);
    tick();
    tick(); bus_ready = 1; bus_rdata = 64'h13; #1;
    check("if_c3_ready", 64'(if_ready), 64'd1);
    check("if_c3_data",  if_rdata, 64'h13);
    tick(); if_v = 0; bus_ready = 0; #1;
    check("if_c4_idle",  64'(bus_valid), 64'd0);

    // Lone MEM write
    mem_v = 1; mem_addr = 64'h8000_1000; mem_wdata = 64'hDEAD_BEEF; mem_req = 1; mem_size = 2'b11;
    tick(); #1;
    check("mw_req",   64'(bus_req), 64'd1);
    check("mw_wdata", bus_wdata, 64'hDEAD_BEEF);
    bus_ready = 1; bus_resp = 2'b10; #1;
    check("mw_ready", 64'(mem_ready), 64'd1);
    check("mw_if_ready", 64'(if_ready), 64'd0);
    tick(); mem_v = 0; bus_ready = 0; #1;
    check("mw_once", 64'(mem_ready), 64'd0);

    // Both held continuously: IF forced in after MAX MEM grants
    mem_req = 0; if_v = 1; mem_v = 1; if_addr = 64'h100; mem_addr = 64'h2000;
    order.delete();
    run_auto(14);
    check_order("order", exp_a, 7);
    if_v = 0; mem_v = 0;
    tick();

    // Mid-grant reset with the starvation counter near its limit
    rst = 1; tick(); rst = 0;
    if_v = 1; mem_v = 1;
    run_auto(6);
    tick(); #1;
    check("pre_rst_grant", 64'(bus_valid), 64'd1);
    rst = 1;
    tick(); rst = 0; #1;
    check("post_rst_valid", 64'(bus_valid), 64'd0);
    check("post_rst_mem_ready", 64'(mem_ready), 64'd0);
    check("post_rst_addr", bus_addr, 64'd0);
    order.delete();
    run_auto(10);
    check_order("rst_order", exp_b, 5);
    if_v = 0; mem_v = 0;
    tick();

    // Spurious ready in IDLE
    for (int k = 0; k < 3; k++) begin
      tick(); bus_ready = 1; #1;
      check("spur_if_ready",  64'(if_ready), 64'd0);
      check("spur_mem_ready", 64'(mem_ready), 64'd0);
      check("spur_valid",     64'(bus_valid), 64'd0);
    end
    bus_ready = 0;

`ifdef IF_MEM_ARB_PERF_EN
    rst = 1; tick(); rst = 0;
    if_v = 1; run_auto(6); if_v = 0;
    mem_v = 1; run_auto(10); mem_v = 0;
    tick(); #1;
    check("perf_if_cnt",  if_cnt,  64'd3);
    check("perf_mem_cnt", mem_cnt, 64'd5);
`endif

    tick();
    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
